// File: rtl/lut_truth_table_sweeper.sv
// Truth-table readback engine for one LogicNets neuron LUT.
// Walks every input code, captures the LUT response and streams the packed
// results LSB-first as WORD_W-bit words over valid/ready.
module lut_truth_table_sweeper #(
  parameter int IN_BITS     = 8,
  parameter int OUT_BITS    = 1,
  parameter int WORD_W      = 32,
  parameter int LUT_LATENCY = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [IN_BITS-1:0]  lut_addr,
  input  logic [OUT_BITS-1:0] lut_data,
  output logic [WORD_W-1:0]   m_tdata,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic                m_tlast
);

  localparam int E  = WORD_W / OUT_BITS;
  localparam int NW = ((1 << IN_BITS) * OUT_BITS) / WORD_W;
  localparam int CW = $clog2(E + 1);
  localparam int WW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [CW-1:0] E_N    = CW'(E);
  localparam logic [CW-1:0] E_LAST = CW'(E - 1);
  localparam logic [WW-1:0] W_LAST = WW'(NW - 1);

  typedef enum logic [1:0] {IDLE, FILL, EMIT, DONE} state_t;

  state_t              state;
  logic [CW-1:0]       iss_cnt;   // addresses issued for the current word
  logic [CW-1:0]       cap_cnt;   // responses captured for the current word
  logic [WW-1:0]       wcnt;
  logic [WORD_W-1:0]   pack;
  logic                issue;
  logic                capture;
  logic [LUT_LATENCY:0] vld_pipe;

  assign issue   = (state == FILL) && (iss_cnt != E_N);
  assign capture = vld_pipe[LUT_LATENCY];
  assign m_tdata = pack;

  generate
    if (LUT_LATENCY == 0) begin : g_nopipe
      assign vld_pipe = issue;
    end else begin : g_pipe
      logic [LUT_LATENCY-1:0] tag_q;
      // Tag pipe tracks which cycles carry a LUT response for an issued address
      always_ff @(posedge clk) begin
        if (rst) tag_q <= '0;
        else     tag_q <= LUT_LATENCY'({tag_q, issue});
      end
      assign vld_pipe = {tag_q, issue};
    end
  endgenerate

  // Sweep control: issue addresses, pack responses, hand off words, pulse done
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      lut_addr <= '0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      iss_cnt  <= '0;
      cap_cnt  <= '0;
      wcnt     <= '0;
      pack     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FILL;
            busy     <= 1'b1;
            lut_addr <= '0;
            iss_cnt  <= '0;
            cap_cnt  <= '0;
            wcnt     <= '0;
            pack     <= '0;
          end
        end
        FILL: begin
          if (issue) begin
            iss_cnt <= iss_cnt + CW'(1);
            // Hold the last address of the word rather than running ahead
            if (iss_cnt != E_LAST) lut_addr <= lut_addr + IN_BITS'(1);
          end
          if (capture) begin
            // Responses return in issue order, so the capture count is the slot
            pack[int'(cap_cnt)*OUT_BITS +: OUT_BITS] <= lut_data;
            cap_cnt <= cap_cnt + CW'(1);
            if (cap_cnt == E_LAST) begin
              state    <= EMIT;
              m_tvalid <= 1'b1;
              m_tlast  <= (wcnt == W_LAST);
            end
          end
        end
        EMIT: begin
          if (m_tready) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            pack     <= '0;
            if (wcnt == W_LAST) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state    <= FILL;
              wcnt     <= wcnt + WW'(1);
              iss_cnt  <= '0;
              cap_cnt  <= '0;
              // Next word starts right after the last address of this one
              lut_addr <= lut_addr + IN_BITS'(1);
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          done     <= 1'b0;
          lut_addr <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/lut_truth_table_sweeper.md
Name: lut_truth_table_sweeper

Overview:
- Built-in sweep engine that reads back the full truth table of one combinational LogicNets neuron LUT.
- Drives every input code 0..2^IN_BITS-1 into the LUT and samples its output each time.
- Packs the sampled outputs LSB-first into WORD_W-bit words and streams them out over a valid/ready interface.
- Used for on-chip LUT verification and bitstream readback, wired between a neuron's input bus and the debug stream.

Parameters:
- IN_BITS, 8: LUT input width; the sweep covers 2^IN_BITS codes.
- OUT_BITS, 1: LUT output width; one entry occupies OUT_BITS bits.
- WORD_W, 32: output stream word width. WORD_W must be a multiple of OUT_BITS, and 2^IN_BITS*OUT_BITS must be a multiple of WORD_W.
- LUT_LATENCY, 0: register stages between lut_addr and lut_data (0 = purely combinational LUT).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep; honoured only in IDLE.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the final word handshake.
- lut_addr  out  IN_BITS  code driven into the LUT under test.
- lut_data  in  OUT_BITS  LUT response, valid LUT_LATENCY cycles after lut_addr.
- m_tdata  out  WORD_W  packed truth-table word.
- m_tvalid  out  1  word valid.
- m_tready  in  1  downstream accept.
- m_tlast  out  1  high with the final word of the sweep.

Behaviour:
- Reset, and the IDLE state: busy=0, done=0, lut_addr=0, m_tvalid=0, m_tlast=0, m_tdata=0. Reset clears all counters and the delay pipe regardless of current state.
- Sizes: E = WORD_W/OUT_BITS entries per word; NW = 2^IN_BITS*OUT_BITS/WORD_W words per sweep. Defaults give E=32, NW=8.
- Packing: entry for code a lands in word a/E at bits [(a%E)*OUT_BITS +: OUT_BITS].
- State IDLE: start=1 -> FILL; address counter=0, word counter=0, pack register cleared.
- State FILL:
  - One new address is issued per cycle on lut_addr, incrementing, until all E addresses of the current word are issued.
  - A valid-tag shift pipe of depth LUT_LATENCY marks which cycles carry a response. With LUT_LATENCY=0, lut_data is captured in the same cycle its address is driven.
  - Each tagged lut_data is written into the pack register at the slot for its address.
  - After issuing stops, lut_addr holds the last issued address.
  - When all E responses are captured -> EMIT.
- State EMIT:
  - m_tvalid=1 and m_tdata holds the packed word; m_tlast=1 only when word counter = NW-1.
  - m_tdata, m_tlast and lut_addr stay stable while m_tvalid=1 and m_tready=0.
  - On handshake (m_tvalid & m_tready): if this was the last word -> DONE; else word counter +1, pack register cleared -> FILL in the next cycle.
- State DONE: done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE.
- Address wrap: the counter never issues past 2^IN_BITS-1. lut_addr returns to 0 only on re-entering IDLE.
- start while busy or in DONE is ignored and has no effect on the current sweep.
- m_tready held high across EMIT->FILL gives one word per E+LUT_LATENCY+1 cycles. No throughput requirement beyond that.
- Reset asserted mid-sweep (any state, including mid-handshake) returns the block to IDLE on the next edge. No partial word is emitted and no done pulse is produced.

Test Plan:
- LUT model out=addr[0], defaults, m_tready=1 -> 8 words, each 0xAAAAAAAA; m_tlast only on word 7; one done pulse; busy high from the cycle after start until the done cycle.
- LUT model constant 1, then constant 0 -> 8 words of 0xFFFFFFFF, then 8 words of 0x00000000, across two back-to-back sweeps.
- LUT model out=(addr==8'h89); m_tready held low 5 cycles during word 4 -> word 4 = 0x00000200 and all other words 0; m_tdata and lut_addr stable during the stall.
- LUT_LATENCY=2 with a registered LUT model out=addr[5] -> words alternate 0x00000000 and 0xFFFFFFFF, starting with 0x00000000; same as the combinational case.
- start re-pulsed during FILL of word 2 -> ignored; exactly 8 words emitted.
- rst pulsed during EMIT of word 3 -> next cycle all outputs 0, state IDLE; a following start yields a clean 8-word sweep beginning at lut_addr=0.
